// File: rtl/math_bk_pkg.sv
// rtl/math_bk_pkg.sv - shared types, constants and prefix operator for the Brent-Kung subtractor
package math_bk_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } bk_pg_t;

  localparam int BK_SUB_STAGES = 3;

  function automatic int bk_levels(input int n);
    return 2 * $clog2(n) - 1;
  endfunction

  // Prefix operator: hi spans the more significant bits, lo the less significant ones.
  function automatic bk_pg_t bk_dot(input bk_pg_t hi, input bk_pg_t lo);
    bk_pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/math_brent_kung_prefix.sv
// rtl/math_brent_kung_prefix.sv - combinational Brent-Kung group-generate tree over N+1 positions
// Position 0 carries the incoming carry; gg[k] is the group generate of positions 0..k.
module math_brent_kung_prefix
  import math_bk_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0] g,
  input  logic [N:0] p,
  output logic [N:0] gg
);

  localparam int M  = N + 1;
  localparam int LV = $clog2(M);

  if (2 * LV - 1 < bk_levels(N)) begin : g_depth_check
    $error("prefix tree shallower than the Brent-Kung depth for N");
  end

  always_comb begin
    bk_pg_t node [M];
    for (int i = 0; i < M; i++) begin
      node[i].g = g[i];
      node[i].p = p[i];
    end
    // Up-sweep: stride 2^(l+1) nodes absorb the block below them.
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < M; i++) begin
        if ((i % (2 << l)) == ((2 << l) - 1)) begin
          node[i] = bk_dot(node[i], node[i - (1 << l)]);
        end
      end
    end
    // Down-sweep: fill the remaining positions from completed prefixes below.
    for (int l = LV - 1; l >= 0; l--) begin
      for (int i = 0; i < M; i++) begin
        if ((i >= (2 << l)) && ((i % (2 << l)) == ((1 << l) - 1))) begin
          node[i] = bk_dot(node[i], node[i - (1 << l)]);
        end
      end
    end
    gg = '0;
    for (int i = 0; i < M; i++) begin
      gg[i] = node[i].g;
    end
  end

endmodule

// File: rtl/math_subtractor_brent_kung_pipe.sv
// rtl/math_subtractor_brent_kung_pipe.sv - 3-stage valid/ready Brent-Kung subtractor, diff = a - b - borrow_in
// Define MATH_SUB_SATURATE_EN to clamp the difference to zero whenever an unsigned borrow-out occurs.
module math_subtractor_brent_kung_pipe
  import math_bk_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_borrow,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_diff,
  output logic         o_borrow,
  output logic         o_ovf
);

  if (N < 4 || N > 64 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("N must be a power of two between 4 and 64");
  end

  logic         s1_vld, s2_vld;
  logic [N:0]   s1_g, s1_p;
  logic         s1_sa, s1_sb, s2_sa, s2_sb;
  logic [N:0]   s2_gg;
  logic [N-1:0] s2_p;
  logic [N:0]   pfx_gg;
  logic         rdy1, rdy2, rdy3;
  logic [N-1:0] raw_diff, diff_nxt;
  logic         brw_nxt, ovf_nxt;

  // A stage may move when it is empty or the stage after it is moving.
  assign rdy3    = ~o_valid | i_ready;
  assign rdy2    = ~s2_vld | rdy3;
  assign rdy1    = ~s1_vld | rdy2;
  assign o_ready = rdy1;

  math_brent_kung_prefix #(.N(N)) u_prefix (
    .g  (s1_g),
    .p  (s1_p),
    .gg (pfx_gg)
  );

  // Carry into operand bit i sits at prefix position i; a carry-out means no borrow.
  assign raw_diff = s2_p ^ s2_gg[N-1:0];
  assign brw_nxt  = ~s2_gg[N];
  assign ovf_nxt  = (s2_sa != s2_sb) && (raw_diff[N-1] != s2_sa);

`ifdef MATH_SUB_SATURATE_EN
  assign diff_nxt = brw_nxt ? '0 : raw_diff;
`else
  assign diff_nxt = raw_diff;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld   <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
      s2_vld   <= 1'b0;
      s2_gg    <= '0;
      s2_p     <= '0;
      s2_sa    <= 1'b0;
      s2_sb    <= 1'b0;
      o_valid  <= 1'b0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      if (rdy1) s1_vld <= i_valid;
      if (rdy1 && i_valid) begin
        s1_g  <= {i_a & ~i_b, ~i_borrow};
        s1_p  <= {i_a ^ ~i_b, 1'b0};
        s1_sa <= i_a[N-1];
        s1_sb <= i_b[N-1];
      end
      if (rdy2) s2_vld <= s1_vld;
      if (rdy2 && s1_vld) begin
        s2_gg <= pfx_gg;
        s2_p  <= s1_p[N:1];
        s2_sa <= s1_sa;
        s2_sb <= s1_sb;
      end
      if (rdy3) o_valid <= s2_vld;
      if (rdy3 && s2_vld) begin
        o_diff   <= diff_nxt;
        o_borrow <= brw_nxt;
        o_ovf    <= ovf_nxt;
      end
    end
  end

endmodule
